// File: rtl/crc_engine_param.sv
// Beat-parallel CRC generator/checker for the I3C HDR link layer.
// Each accepted beat folds DATA_W bits into a CRC_W-bit LFSR in one cycle.
// The final CRC, and the match/error flags in check mode, are registered
// when the last beat is accepted. They are held in DONE until i_crc_ack.
module crc_engine_param #(
    parameter int                CRC_W     = 5,
    parameter int                DATA_W    = 8,
    parameter logic [CRC_W-1:0]  POLY      = 5'h05,
    parameter logic [CRC_W-1:0]  INIT      = 5'h1F,
    parameter logic [CRC_W-1:0]  XOR_OUT   = 5'h00,
    parameter bit                LSB_FIRST = 1'b0
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_enable,
    input  logic              i_chk_mode,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_data_valid,
    input  logic              i_data_last,
    output logic              o_data_ready,
    input  logic [CRC_W-1:0]  i_rx_crc,
    output logic [CRC_W-1:0]  o_crc_value,
    output logic              o_crc_valid,
    input  logic              i_crc_ack,
    output logic              o_crc_match,
    output logic              o_crc_err,
    output logic              o_busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state, state_nxt;
    logic [CRC_W-1:0]   lfsr;
    logic               mode_q;
    logic               accept;
    logic               mode_eff;
    logic [CRC_W-1:0]   lfsr_base;
    logic [CRC_W-1:0]   lfsr_fold;
    logic [CRC_W-1:0]   crc_final;

    // Unrolled serial LFSR: DATA_W single-bit steps in beat order.
    function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] s,
                                              input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = s;
        for (int i = 0; i < DATA_W; i++) begin
            fb = r[CRC_W-1] ^ (LSB_FIRST ? d[i] : d[DATA_W-1-i]);
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    assign accept    = i_data_valid & o_data_ready;
    // A frame always starts from INIT, whatever the register holds.
    assign lfsr_base = (state == IDLE) ? INIT : lfsr;
    assign lfsr_fold = fold(lfsr_base, i_data_in);
    assign crc_final = lfsr_fold ^ XOR_OUT;
    // Mode is taken live on the first beat and from the latch afterwards.
    assign mode_eff  = (state == IDLE) ? i_chk_mode : mode_q;

    // State register.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic; dropping enable overrides everything, including ack.
    always_comb begin
        state_nxt = state;
        if (!i_enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = i_data_last ? DONE : ACCUM;
                ACCUM:   if (accept && i_data_last) state_nxt = DONE;
                DONE:    if (i_crc_ack) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State-decoded outputs; ready is also gated off while reset is asserted.
    always_comb begin
        o_data_ready = i_enable & ~i_sys_rst & (state != DONE);
        o_crc_valid  = (state == DONE);
        o_busy       = (state != IDLE);
    end

    // LFSR, latched mode and registered result.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            lfsr        <= INIT;
            mode_q      <= 1'b0;
            o_crc_value <= '0;
            o_crc_match <= 1'b0;
            o_crc_err   <= 1'b0;
        end else if (!i_enable) begin
            lfsr        <= INIT;
            mode_q      <= 1'b0;
            o_crc_value <= '0;
            o_crc_match <= 1'b0;
            o_crc_err   <= 1'b0;
        end else if (state == DONE) begin
            if (i_crc_ack) begin
                lfsr        <= INIT;
                mode_q      <= 1'b0;
                o_crc_value <= '0;
                o_crc_match <= 1'b0;
                o_crc_err   <= 1'b0;
            end
        end else if (accept) begin
            mode_q <= mode_eff;
            if (i_data_last) begin
                lfsr        <= INIT;
                o_crc_value <= crc_final;
                o_crc_match <= mode_eff & (crc_final == i_rx_crc);
                o_crc_err   <= mode_eff & (crc_final != i_rx_crc);
            end else begin
                lfsr        <= lfsr_fold;
            end
        end
    end

endmodule

// File: tb/tb_crc_engine_param.sv
// Scoreboard bench for crc_engine_param. Three instances share their control
// inputs: default CRC-5, CRC-5 with INIT=0, and a 16-bit LSB-first variant.
// Expected results come from a polynomial long-division model.
module tb_crc_engine_param;

    typedef struct {
        logic [31:0] v;
        logic        m;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en, chk_mode, vld, last, ack;
    logic [7:0]  din_ab;
    logic [15:0] din_c;
    logic [4:0]  rx_ab;
    logic [15:0] rx_c;
    logic        rdy_a, val_a, m_a, e_a, busy_a;
    logic        rdy_b, val_b, m_b, e_b, busy_b;
    logic        rdy_c, val_c, m_c, e_c, busy_c;
    logic [4:0]  cv_a, cv_b;
    logic [15:0] cv_c;

    exp_t qa[$], qb[$], qc[$];
    logic        pv_a, pv_b, pv_c;
    logic [4:0]  last_a, last_b;
    logic        lm_a, le_a;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    crc_engine_param u_a (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_enable(en), .i_chk_mode(chk_mode),
        .i_data_in(din_ab), .i_data_valid(vld), .i_data_last(last),
        .o_data_ready(rdy_a), .i_rx_crc(rx_ab), .o_crc_value(cv_a),
        .o_crc_valid(val_a), .i_crc_ack(ack), .o_crc_match(m_a),
        .o_crc_err(e_a), .o_busy(busy_a));

    crc_engine_param #(.INIT(5'h00)) u_b (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_enable(en), .i_chk_mode(chk_mode),
        .i_data_in(din_ab), .i_data_valid(vld), .i_data_last(last),
        .o_data_ready(rdy_b), .i_rx_crc(rx_ab), .o_crc_value(cv_b),
        .o_crc_valid(val_b), .i_crc_ack(ack), .o_crc_match(m_b),
        .o_crc_err(e_b), .o_busy(busy_b));

    crc_engine_param #(.CRC_W(16), .DATA_W(16), .POLY(16'h8005), .INIT(16'hFFFF),
                       .XOR_OUT(16'h00FF), .LSB_FIRST(1'b1)) u_c (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_enable(en), .i_chk_mode(chk_mode),
        .i_data_in(din_c), .i_data_valid(vld), .i_data_last(last),
        .o_data_ready(rdy_c), .i_rx_crc(rx_c), .o_crc_value(cv_c),
        .o_crc_valid(val_c), .i_crc_ack(ack), .o_crc_match(m_c),
        .o_crc_err(e_c), .o_busy(busy_c));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic note_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got event want none", nm);
    endtask

    // CRC as polynomial remainder: (INIT*x^L + M(x)*x^W) mod G(x), then XOR_OUT.
    function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input logic [31:0] xo,
                                            input bit lsb, input int dw, input logic [63:0] q[$]);
        bit          d[$];
        int          len;
        logic [31:0] r;
        foreach (q[i])
            for (int k = 0; k < dw; k++)
                d.push_back(lsb ? q[i][k] : q[i][dw-1-k]);
        len = d.size();
        for (int k = 0; k < w; k++) d.push_back(1'b0);
        for (int b = 0; b < w; b++) d[w-1-b] ^= init[b];
        for (int j = 0; j < len; j++)
            if (d[j])
                for (int k = 0; k < w; k++) d[j+1+k] ^= poly[w-1-k];
        r = '0;
        for (int k = 0; k < w; k++) r[w-1-k] = d[len+k];
        return r ^ xo;
    endfunction

    // Monitors: pop one expectation per rising o_crc_valid; idle outputs must be zero.
    always @(negedge clk) begin : mon_a
        exp_t ex;
        if (rst) pv_a <= 1'b0;
        else begin
            if (val_a && !pv_a) begin
                if (qa.size() == 0) note_fail("a_unexpected_result");
                else begin
                    ex = qa.pop_front();
                    chk("a_value", 32'(cv_a), ex.v);
                    chk("a_match", 32'(m_a), 32'(ex.m));
                    chk("a_err", 32'(e_a), 32'(ex.e));
                    last_a <= cv_a; lm_a <= m_a; le_a <= e_a;
                end
            end
            if (!val_a) chk("a_idle_outputs", {cv_a, m_a, e_a}, 32'd0);
            pv_a <= val_a;
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t ex;
        if (rst) pv_b <= 1'b0;
        else begin
            if (val_b && !pv_b) begin
                if (qb.size() == 0) note_fail("b_unexpected_result");
                else begin
                    ex = qb.pop_front();
                    chk("b_value", 32'(cv_b), ex.v);
                    chk("b_match", 32'(m_b), 32'(ex.m));
                    chk("b_err", 32'(e_b), 32'(ex.e));
                    last_b <= cv_b;
                end
            end
            pv_b <= val_b;
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t ex;
        if (rst) pv_c <= 1'b0;
        else begin
            if (val_c && !pv_c) begin
                if (qc.size() == 0) note_fail("c_unexpected_result");
                else begin
                    ex = qc.pop_front();
                    chk("c_value", 32'(cv_c), ex.v);
                    chk("c_match", 32'(m_c), 32'(ex.m));
                    chk("c_err", 32'(e_c), 32'(ex.e));
                end
            end
            if (!val_c) chk("c_idle_outputs", {cv_c, m_c, e_c}, 32'd0);
            pv_c <= val_c;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame on all three engines. seqgap: gap before beat i is i cycles.
    // drop: finish by dropping enable together with ack instead of a plain ack.
    task automatic frame(input int n, input bit mode, input bit zero, input bit seqgap,
                         input int gmax, input bit badrx, input int hold, input bit drop);
        logic [63:0] ba[$], bc[$];
        logic [31:0] va, vb, vc;
        logic [4:0]  rab;
        logic [15:0] rc;
        logic [4:0]  held;
        exp_t        ea, eb, ec;
        int          g;
        for (int i = 0; i < n; i++) begin
            ba.push_back(zero ? 64'd0 : 64'($urandom_range(255, 0)));
            bc.push_back(zero ? 64'd0 : 64'($urandom_range(65535, 0)));
        end
        va  = ref_crc(5, 32'h05, 32'h1F, 32'h00, 1'b0, 8, ba);
        vb  = ref_crc(5, 32'h05, 32'h00, 32'h00, 1'b0, 8, ba);
        vc  = ref_crc(16, 32'h8005, 32'hFFFF, 32'h00FF, 1'b1, 16, bc);
        rab = badrx ? (va[4:0] ^ 5'h01) : va[4:0];
        rc  = badrx ? (vc[15:0] ^ 16'h0001) : vc[15:0];
        ea.v = va; ea.m = mode && (rab == va[4:0]);  ea.e = mode && (rab != va[4:0]);
        eb.v = vb; eb.m = mode && (rab == vb[4:0]);  eb.e = mode && (rab != vb[4:0]);
        ec.v = vc; ec.m = mode && (rc == vc[15:0]);  ec.e = mode && (rc != vc[15:0]);
        qa.push_back(ea); qb.push_back(eb); qc.push_back(ec);
        for (int i = 0; i < n; i++) begin
            g = seqgap ? i : $urandom_range(gmax, 0);
            repeat (g) begin
                vld = 1'b0; last = 1'($urandom); chk_mode = 1'($urandom);
                rx_ab = 5'($urandom); rx_c = 16'($urandom);
                din_ab = 8'($urandom); din_c = 16'($urandom);
                tick();
            end
            vld = 1'b1; last = (i == n - 1);
            din_ab = ba[i][7:0]; din_c = bc[i][15:0];
            chk_mode = (i == 0) ? mode : 1'($urandom);
            rx_ab = (i == n - 1) ? rab : 5'($urandom);
            rx_c  = (i == n - 1) ? rc : 16'($urandom);
            tick();
        end
        vld = 1'b0; last = 1'b0; chk_mode = 1'($urandom);
        rx_ab = 5'($urandom); rx_c = 16'($urandom);
        chk("latency_valid_a", 32'(val_a), 32'd1);
        chk("latency_valid_c", 32'(val_c), 32'd1);
        held = cv_a;
        repeat (hold) begin
            vld = 1'($urandom); last = 1'($urandom);
            din_ab = 8'($urandom); din_c = 16'($urandom);
            tick();
            chk("hold_ready_a", 32'(rdy_a), 32'd0);
            chk("hold_valid_a", 32'(val_a), 32'd1);
            chk("hold_value_a", 32'(cv_a), 32'(held));
        end
        vld = 1'b0; last = 1'b0;
        if (drop) en = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0; en = 1'b1;
        chk("post_ack_valid_a", 32'(val_a), 32'd0);
        chk("post_ack_busy_a", 32'(busy_a), 32'd0);
        chk("post_ack_value_a", 32'(cv_a), 32'd0);
        chk("post_ack_valid_c", 32'(val_c), 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; chk_mode = 1'b0; vld = 1'b0; last = 1'b0; ack = 1'b0;
        din_ab = '0; din_c = '0; rx_ab = '0; rx_c = '0;
        repeat (2) tick();
        chk("reset_ready", 32'(rdy_a), 32'd0);
        chk("reset_valid", 32'(val_a), 32'd0);
        chk("reset_value", 32'(cv_a), 32'd0);
        chk("reset_flags", {m_a, e_a}, 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        en = 1'b1;
        chk("reset_ready_enabled", 32'(rdy_a), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(rdy_a), 32'd1);

        // Single zero beat, generate mode: CRC-5 of 8'h00 from 5'h1F is 5'h0F.
        frame(1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("gen_zero_beat", 32'(last_a), 32'h0F);
        chk("gen_flags", {lm_a, le_a}, 32'd0);
        // Check mode, matching then mismatching received CRC.
        frame(1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("chk_match", {lm_a, le_a}, 32'b10);
        frame(1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 0, 1'b0);
        chk("chk_mismatch", {lm_a, le_a}, 32'b01);
        // Four zero beats with 0..3 idle gaps; INIT=0 engine must give 0.
        frame(4, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0);
        chk("init0_gaps", 32'(last_b), 32'h00);
        // Result held for five cycles with extra beats offered.
        frame(3, 1'b1, 1'b0, 1'b0, 1, 1'b0, 5, 1'b0);

        // Abort after two beats, then a clean single zero beat.
        vld = 1'b1; last = 1'b0; din_ab = 8'hA5; din_c = 16'h1234;
        tick(); tick();
        vld = 1'b0; en = 1'b0;
        tick();
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_ready", 32'(rdy_a), 32'd0);
        en = 1'b1;
        frame(1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("after_abort", 32'(last_a), 32'h0F);

        // Enable dropped together with ack while a result is pending.
        frame(2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1, 1'b1);

        // Ack outside DONE is ignored.
        ack = 1'b1; tick(); ack = 1'b0;
        chk("stray_ack_busy", 32'(busy_a), 32'd0);

        // Async reset mid-frame: immediate return to reset values.
        vld = 1'b1; last = 1'b0; din_ab = 8'h3C;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy_a), 32'd0);
        chk("async_rst_valid", 32'(val_a), 32'd0);
        vld = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Randomized frames.
        for (int f = 0; f < 40; f++)
            frame($urandom_range(64, 1), 1'($urandom), 1'b0, 1'b0, 2,
                  1'($urandom), $urandom_range(3, 0), 1'b0);

        tick();
        chk("queue_a_empty", 32'(qa.size()), 32'd0);
        chk("queue_b_empty", 32'(qb.size()), 32'd0);
        chk("queue_c_empty", 32'(qc.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
